wb_drt_table: RTL
=================

WB_DRT_TABLE -- requirements
Module: wb_drt_table

Interface
REQ-001 SHALL: parameter NUM_DEVICES, default 1, number of device entries; legal range 1..64.
REQ-002 SHALL: parameter DRT_ID, default 16'h0001, table identifier.
REQ-003 SHALL: parameter DRT_VERSION, default 16'h0002, table format version.
REQ-004 SHALL: parameter DEV_TABLE, width NUM_DEVICES*128, default all-zero; holds the device entries, four 32-bit words per device.
REQ-005 SHALL: clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL: wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe and write-enable.
REQ-008 SHALL: wbs_adr_i  input  32  word address.
REQ-009 SHALL: wbs_dat_i  input  32  write data; contents ignored.
REQ-010 SHALL: wbs_dat_o  output  32  read data, registered.
REQ-011 SHALL: wbs_ack_o  output  1  acknowledge, registered.
REQ-012 SHALL: wbs_int_o  output  1  interrupt, registered.

Function
REQ-013 SHALL: table size TBL_WORDS = 4 + 4*NUM_DEVICES; the address compare SHALL use all 32 bits of wbs_adr_i.
REQ-014 SHALL: word 0 = {DRT_ID, DRT_VERSION}; word 1 = NUM_DEVICES, zero-extended to 32 bits; word 2 = status word (REQ-026), or 0 when DRT_ERR_INT_EN is not defined; word 3 = 0.
REQ-015 SHALL: word 4+4k+j (k = 0..NUM_DEVICES-1, j = 0..3) = DEV_TABLE[(4k+j)*32 +: 32]; j = 0 device ID, j = 1 flags, j = 2 memory offset, j = 3 memory size.
REQ-016 SHALL: a read with wbs_adr_i >= TBL_WORDS returns 32'h0.
REQ-017 SHALL: the block uses a three-state FSM: IDLE, ACK, WAIT.
REQ-018 SHALL: IDLE -> ACK when wbs_cyc_i & wbs_stb_i. On that edge, for a read, wbs_dat_o is loaded from the addressed word; for a write, wbs_dat_o is left unchanged.
REQ-019 SHALL: in ACK, wbs_ack_o = 1 for exactly one cycle, giving a latency of 1 cycle from the strobe to the acknowledge; the next state is WAIT.
REQ-020 SHALL: WAIT -> IDLE when wbs_stb_i = 0; the FSM stays in WAIT while wbs_stb_i = 1, so a held strobe is never acknowledged twice.
REQ-021 SHALL: if wbs_cyc_i drops while in ACK, the FSM goes to IDLE and wbs_dat_o holds its value.
REQ-022 SHALL: writes are acknowledged exactly like reads and never change any table word.
REQ-023 SHALL: wbs_dat_o holds its last value between accesses.

Reset
REQ-024 SHALL: when rst = 1, the FSM goes to IDLE and wbs_dat_o = 0, wbs_ack_o = 0, wbs_int_o = 0; the violation counter and error flag clear.
REQ-025 SHALL: rst asserted during ACK or WAIT drops wbs_ack_o on the same edge; a strobe still held after reset releases starts a new access.

Configuration
REQ-026 SHALL: macro DRT_ERR_INT_EN defined -> every access that is a write or has wbs_adr_i >= TBL_WORDS, counted when it enters ACK, sets a sticky error flag and increments an 8-bit violation counter that saturates at 8'hFF.
REQ-027 SHALL: with DRT_ERR_INT_EN defined -> wbs_int_o = error flag, registered; word 2 reads {23'h0, flag, counter}.
REQ-028 SHALL: with DRT_ERR_INT_EN defined -> a read of word 2 returns the pre-clear value, then clears the flag and counter on the same edge that loads wbs_dat_o. If a violation occurs on that same edge, the new violation wins: flag = 1, counter = 1.
REQ-029 SHALL: DRT_ERR_INT_EN not defined -> no counter or flag is implemented, wbs_int_o is tied to 0, and word 2 reads 0.

Verification
REQ-030 SHALL: NUM_DEVICES=2, DRT_VERSION=16'h0002, read addresses 0..11 -> word 0 = 32'h00010002, word 1 = 32'h2, words 4..11 equal the DEV_TABLE slices; each ack arrives 1 cycle after the strobe.
REQ-031 SHALL: strobe held for 5 cycles on address 1 -> exactly one wbs_ack_o pulse; the next strobe is accepted only after wbs_stb_i has been low.
REQ-032 SHALL: read address 32'h0000_0100 with NUM_DEVICES=1 -> wbs_dat_o = 0, ack given; with DRT_ERR_INT_EN defined -> wbs_int_o = 1 and word 2 = 32'h0000_0101.
REQ-033 SHALL: with DRT_ERR_INT_EN defined: 300 writes -> counter = 8'hFF; read word 2 -> 32'h0000_01FF, and a second read -> 0 with wbs_int_o = 0.
REQ-034 SHALL: rst pulsed during ACK -> wbs_ack_o = 0 on the next edge, all outputs 0, and a fresh strobe afterwards is served normally.
REQ-035 SHALL: wbs_cyc_i dropped during ACK -> FSM returns to IDLE and no stale ack appears on the next access.

Source files
------------

// File: rtl/wb_drt_table.sv
// Read-only Wishbone device-registry table: a 4-word header followed by four words per device.
// Define DRT_ERR_INT_EN to add the violation counter, sticky error flag and wbs_int_o.
module wb_drt_table #(
  parameter int unsigned                 NUM_DEVICES = 1,
  parameter logic [15:0]                 DRT_ID      = 16'h0001,
  parameter logic [15:0]                 DRT_VERSION = 16'h0002,
  parameter logic [NUM_DEVICES*128-1:0]  DEV_TABLE   = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_int_o
);

  localparam int unsigned TBL_WORDS = 4 + 4 * NUM_DEVICES;
  localparam int unsigned DEV_WORDS = 4 * NUM_DEVICES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic [31:0] status_word;
  logic [31:0] rd_word;
  logic [31:0] dev_words [DEV_WORDS];

  // The table is write-protected; incoming write data is never stored.
  logic unused_dat;
  assign unused_dat = ^wbs_dat_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEV_WORDS; gi++) begin : g_dev
      assign dev_words[gi] = DEV_TABLE[gi*32 +: 32];
    end
  endgenerate

  // Full 32-bit compare, so high address bits never alias onto table words.
  always_comb begin
    rd_word = 32'h0;
    if (wbs_adr_i == 32'd0) begin
      rd_word = {DRT_ID, DRT_VERSION};
    end else if (wbs_adr_i == 32'd1) begin
      rd_word = 32'(NUM_DEVICES);
    end else if (wbs_adr_i == 32'd2) begin
      rd_word = status_word;
    end
    for (int i = 0; i < DEV_WORDS; i++) begin
      if (wbs_adr_i == 32'(i + 4)) begin
        rd_word = dev_words[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ACK;
          if (!wbs_we_i) begin
            dat_d = rd_word;
          end
        end
      end
      ACK: begin
        state_d = wbs_cyc_i ? WAIT : IDLE;
      end
      WAIT: begin
        if (!wbs_stb_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dat_q   <= 32'h0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;

`ifdef DRT_ERR_INT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       start;
  logic       viol;
  logic       clr;

  assign start = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign viol  = start && (wbs_we_i || (wbs_adr_i >= 32'(TBL_WORDS)));
  assign clr   = start && !wbs_we_i && (wbs_adr_i == 32'd2);

  // Clear-on-read is applied first so a coincident violation still registers.
  always_comb begin
    cnt_d  = clr ? 8'h00 : cnt_q;
    flag_d = clr ? 1'b0 : flag_q;
    if (viol) begin
      flag_d = 1'b1;
      if (cnt_d != 8'hFF) begin
        cnt_d = cnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'h00;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign status_word = {23'h0, flag_q, cnt_q};
  assign wbs_int_o   = flag_q;
`else
  assign status_word = 32'h0;
  assign wbs_int_o   = 1'b0;
`endif

endmodule
